decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 47 ++++
 rtl/decode_stage_decode_logic.sv | 77 +++++++
 rtl/decode_stage.sv | 111 +++++++++++
 tb/tb_decode_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode classes, ALU select codes
// and the decoded control bundle carried by the output register.
package decode_stage_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_CTL = 2'b10,
    OP_ALU = 2'b11
  } op_e;

  localparam logic [4:0] C5_LI  = 5'b10000;
  localparam logic [4:0] C5_BR  = 5'b10100;
  localparam logic [4:0] C5_BRL = 5'b10111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SLR = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_IDT = 4'b1100;
  localparam logic [3:0] ALU_NON = 4'b1111;

  typedef struct packed {
    logic       sign_ex;
    logic       ar_mux;
    logic       br_mux;
    logic       in_mux;
    logic       adr_mux;
    logic       write;
    logic       pc_load;
    logic       mem_we;
    logic [3:0] alu_sel;
    logic [2:0] wr_addr;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = bundle_t'({8'h00, ALU_NON, 3'b000});

  function automatic logic [7:0] reg_bit(input logic [2:0] addr);
    reg_bit = 8'h01 << addr;
  endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Pure combinational instruction decoder: control bundle plus the mask of
// registers the instruction touches (reads and destination).
module decode_logic
  import decode_stage_pkg::*;
(
  input  logic [15:0] cmd_i,
  output bundle_t     dec_o,
  output logic [7:0]  use_mask_o
);

  op_e        op_s;
  logic [3:0] fn_s;
  logic [2:0] ra_s;
  logic [2:0] rb_s;
  logic [4:0] c5_s;
  logic       is_alu_s;
  logic       is_li_s;
  logic       is_br_s;

  assign op_s     = op_e'(cmd_i[15:14]);
  assign fn_s     = cmd_i[7:4];
  assign ra_s     = cmd_i[13:11];
  assign rb_s     = cmd_i[10:8];
  assign c5_s     = cmd_i[15:11];
  assign is_alu_s = (op_s == OP_ALU);
  assign is_li_s  = (c5_s == C5_LI);
  assign is_br_s  = (c5_s == C5_BR) || (c5_s == C5_BRL);

  always_comb begin
    dec_o         = BUNDLE_RST;
    use_mask_o    = 8'h00;
    dec_o.sign_ex = is_alu_s;
    dec_o.ar_mux  = is_alu_s && (fn_s <= 4'b0110);
    dec_o.br_mux  = (op_s != OP_CTL);
    dec_o.in_mux  = is_alu_s && (fn_s == 4'b1100);
    dec_o.adr_mux = (is_alu_s && (fn_s <= 4'b1011)) || (op_s == OP_CTL);
    dec_o.write   = (is_alu_s && (fn_s <= 4'b1100)) || (op_s == OP_LD) || is_li_s;
    dec_o.pc_load = is_br_s;
    dec_o.mem_we  = (op_s == OP_ST);
    case (op_s)
      OP_ALU: begin
        case (fn_s)
          4'b0101: dec_o.alu_sel = ALU_SUB;
          4'b0110: dec_o.alu_sel = ALU_IDT;
          default: dec_o.alu_sel = fn_s;
        endcase
      end
      OP_LD, OP_ST: dec_o.alu_sel = ALU_ADD;
      default: begin
        if (is_li_s) begin
          dec_o.alu_sel = ALU_IDT;
        end else if (is_br_s) begin
          dec_o.alu_sel = ALU_ADD;
        end else begin
          dec_o.alu_sel = ALU_NON;
        end
      end
    endcase
    // LD targets A; ALU and LI target B
    if (!dec_o.write) begin
      dec_o.wr_addr = 3'd0;
    end else if (op_s == OP_LD) begin
      dec_o.wr_addr = ra_s;
    end else begin
      dec_o.wr_addr = rb_s;
    end
    // ALU, LD and ST all touch A and B; LI touches only B; branches none
    if (op_s != OP_CTL) begin
      use_mask_o = reg_bit(ra_s) | reg_bit(rb_s);
    end else if (is_li_s) begin
      use_mask_o = reg_bit(rb_s);
    end else begin
      use_mask_o = 8'h00;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one output register with valid/ready handshake and
// an 8-entry register-hazard scoreboard cleared by writeback strobes.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int SB_EN = 1,
  parameter int NWB   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_cmd,
  input  logic             flush,
  input  logic [NWB-1:0]   wb_valid,
  input  logic [3*NWB-1:0] wb_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign_ex,
  output logic             out_ar_mux,
  output logic             out_br_mux,
  output logic             out_in_mux,
  output logic             out_adr_mux,
  output logic             out_write,
  output logic             out_pc_load,
  output logic             out_mem_we,
  output logic [3:0]       out_alu_sel,
  output logic [2:0]       out_wr_addr,
  output logic [15:0]      out_cmd,
  output logic             busy
);

  bundle_t     dec_s;
  bundle_t     bundle_q, bundle_d;
  logic [15:0] cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic [7:0]  sb_q, sb_d;
  logic [7:0]  use_mask_s;
  logic [7:0]  clr_mask_s;
  logic [7:0]  sb_live_s;
  logic [7:0]  kill_mask_s;
  logic [7:0]  set_mask_s;
  logic        hazard_s;
  logic        accept_s;

  decode_logic u_decode (
    .cmd_i      (in_cmd),
    .dec_o      (dec_s),
    .use_mask_o (use_mask_s)
  );

  always_comb begin
    clr_mask_s = 8'h00;
    for (int i = 0; i < NWB; i++) begin
      clr_mask_s = clr_mask_s | (wb_valid[i] ? reg_bit(wb_addr[3*i +: 3]) : 8'h00);
    end
  end

  // Hazard is judged against the scoreboard after this cycle's clears
  assign sb_live_s   = sb_q & ~clr_mask_s;
  assign hazard_s    = (SB_EN != 0) && (|(use_mask_s & sb_live_s));
  assign in_ready    = (!valid_q || out_ready) && !hazard_s && !flush;
  assign accept_s    = in_valid && in_ready;
  assign kill_mask_s = (flush && valid_q && bundle_q.write) ? reg_bit(bundle_q.wr_addr) : 8'h00;
  assign set_mask_s  = (accept_s && dec_s.write) ? reg_bit(dec_s.wr_addr) : 8'h00;

  always_comb begin
    bundle_d = bundle_q;
    cmd_d    = cmd_q;
    valid_d  = valid_q;
    sb_d     = (SB_EN != 0) ? ((sb_live_s & ~kill_mask_s) | set_mask_s) : 8'h00;
    if (accept_s) begin
      valid_d  = 1'b1;
      bundle_d = dec_s;
      cmd_d    = in_cmd;
    end else if (flush || out_ready) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= BUNDLE_RST;
      cmd_q    <= 16'h0000;
      sb_q     <= 8'h00;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cmd_q    <= cmd_d;
      sb_q     <= sb_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_sign_ex = bundle_q.sign_ex;
  assign out_ar_mux  = bundle_q.ar_mux;
  assign out_br_mux  = bundle_q.br_mux;
  assign out_in_mux  = bundle_q.in_mux;
  assign out_adr_mux = bundle_q.adr_mux;
  assign out_write   = bundle_q.write;
  assign out_pc_load = bundle_q.pc_load;
  assign out_mem_we  = bundle_q.mem_we;
  assign out_alu_sel = bundle_q.alu_sel;
  assign out_wr_addr = bundle_q.wr_addr;
  assign out_cmd     = cmd_q;
  assign busy        = valid_q || (|sb_q);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench: directed handshake/hazard/flush/reset scenarios and
// random traffic against a reference model, plus a full opcode sweep.
`timescale 1ns/1ps
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Main instance: scoreboard on, two writeback ports
  logic        rst, in_valid, flush, out_ready;
  logic [15:0] in_cmd;
  logic [1:0]  wb_valid;
  logic [5:0]  wb_addr;
  logic        in_ready, out_valid, busy;
  logic        out_sign_ex, out_ar_mux, out_br_mux, out_in_mux;
  logic        out_adr_mux, out_write, out_pc_load, out_mem_we;
  logic [3:0]  out_alu_sel;
  logic [2:0]  out_wr_addr;
  logic [15:0] out_cmd;
  logic [14:0] got_b;

  decode_stage #(.SB_EN(1), .NWB(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_ex(out_sign_ex), .out_ar_mux(out_ar_mux), .out_br_mux(out_br_mux),
    .out_in_mux(out_in_mux), .out_adr_mux(out_adr_mux), .out_write(out_write),
    .out_pc_load(out_pc_load), .out_mem_we(out_mem_we), .out_alu_sel(out_alu_sel),
    .out_wr_addr(out_wr_addr), .out_cmd(out_cmd), .busy(busy)
  );
  assign got_b = {out_sign_ex, out_ar_mux, out_br_mux, out_in_mux, out_adr_mux,
                  out_write, out_pc_load, out_mem_we, out_alu_sel, out_wr_addr};

  // Sweep instance: scoreboard removed, single writeback port
  logic        s_rst, s_valid;
  logic [15:0] s_cmd;
  logic        s_flush = 1'b0;
  logic        s_ordy = 1'b1;
  logic [0:0]  s_wbv = 1'b0;
  logic [2:0]  s_wba = 3'd0;
  logic        s_in_ready, s_out_valid, s_busy;
  logic        s_sign_ex, s_ar_mux, s_br_mux, s_in_mux, s_adr_mux, s_write, s_pc_load, s_mem_we;
  logic [3:0]  s_alu_sel;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_out_cmd;
  logic [14:0] s_bund;

  decode_stage #(.SB_EN(0), .NWB(1)) dut_nosb (
    .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_cmd(s_cmd), .flush(s_flush), .wb_valid(s_wbv), .wb_addr(s_wba),
    .out_valid(s_out_valid), .out_ready(s_ordy),
    .out_sign_ex(s_sign_ex), .out_ar_mux(s_ar_mux), .out_br_mux(s_br_mux),
    .out_in_mux(s_in_mux), .out_adr_mux(s_adr_mux), .out_write(s_write),
    .out_pc_load(s_pc_load), .out_mem_we(s_mem_we), .out_alu_sel(s_alu_sel),
    .out_wr_addr(s_wr_addr), .out_cmd(s_out_cmd), .busy(s_busy)
  );
  assign s_bund = {s_sign_ex, s_ar_mux, s_br_mux, s_in_mux, s_adr_mux,
                   s_write, s_pc_load, s_mem_we, s_alu_sel, s_wr_addr};

  localparam logic [14:0] RST_B = {8'h00, 4'hF, 3'h0};

  // Reference model state
  logic        m_valid;
  logic [7:0]  m_sb;
  logic [14:0] m_bund;
  logic [15:0] m_cmd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected controls {sign,ar,br,in,adr,write,pc,we,alu[3:0],wr[2:0]}
  function automatic logic [14:0] ref_dec(input logic [15:0] c);
    int op, fn, a, b, c5, sel, wra;
    bit alu, li, br, wr;
    op  = int'(c[15:14]);
    fn  = int'(c[7:4]);
    a   = int'(c[13:11]);
    b   = int'(c[10:8]);
    c5  = int'(c[15:11]);
    alu = (op == 3);
    li  = (c5 == 16);
    br  = (c5 == 20) || (c5 == 23);
    wr  = (alu && fn <= 12) || (op == 0) || li;
    if (alu)         sel = (fn == 5) ? 1 : (fn == 6) ? 12 : fn;
    else if (op < 2) sel = 0;
    else if (li)     sel = 12;
    else if (br)     sel = 0;
    else             sel = 15;
    wra = !wr ? 0 : (op == 0) ? a : b;
    return {alu, alu && fn <= 6, op != 2, alu && fn == 12, (alu && fn <= 11) || op == 2,
            wr, br, op == 1, 4'(sel), 3'(wra)};
  endfunction

  function automatic logic [7:0] ref_uses(input logic [15:0] c);
    int a, b;
    a = int'(c[13:11]);
    b = int'(c[10:8]);
    if (c[15:14] != 2'b10) return 8'((1 << a) | (1 << b));
    if (c[15:11] == 5'b10000) return 8'(1 << b);
    return 8'h00;
  endfunction

  // One cycle on the main instance, checked against the model
  task automatic step(input logic v, input logic [15:0] c, input logic ordy, input logic fl,
                      input logic [1:0] wv, input logic [5:0] wa, input logic r);
    logic [7:0]  live;
    logic [14:0] e;
    logic        rdy, acc;
    @(negedge clk);
    rst = r; in_valid = v; in_cmd = c; out_ready = ordy; flush = fl;
    wb_valid = wv; wb_addr = wa;
    #1;
    live = m_sb;
    if (wv[0]) live[wa[2:0]] = 1'b0;
    if (wv[1]) live[wa[5:3]] = 1'b0;
    rdy = (!m_valid || ordy) && ((ref_uses(c) & live) == 8'h00) && !fl;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = v && rdy;
    if (r) begin
      m_valid = 1'b0; m_sb = 8'h00; m_bund = RST_B; m_cmd = 16'h0000;
    end else begin
      if (fl && m_valid && m_bund[9]) live[m_bund[2:0]] = 1'b0;
      if (acc) begin
        e = ref_dec(c);
        if (e[9]) live[e[2:0]] = 1'b1;
        m_bund = e; m_cmd = c; m_valid = 1'b1;
      end else if (fl || ordy) begin
        m_valid = 1'b0;
      end
      m_sb = live;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("bundle", {17'd0, got_b}, {17'd0, m_bund});
    check_eq("out_cmd", {16'd0, out_cmd}, {16'd0, m_cmd});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_valid || (m_sb != 8'h00))});
  endtask

  initial begin
    logic [15:0] c;
    checks = 0; errors = 0;
    m_valid = 1'b0; m_sb = 8'h00; m_bund = RST_B; m_cmd = 16'h0000;
    rst = 1'b1; in_valid = 1'b0; in_cmd = 16'h0000; flush = 1'b0; out_ready = 1'b1;
    wb_valid = 2'b00; wb_addr = 6'd0;
    s_rst = 1'b1; s_valid = 1'b0; s_cmd = 16'h0000;

    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b00, 6'd0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b00, 6'd0, 1'b1);
    check_eq("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // ALU CMP r0,r0
    step(1'b1, 16'hC050, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    check_eq("cmp_alu_sel", {28'd0, out_alu_sel}, 32'h1);
    check_eq("cmp_ctl", {27'd0, out_ar_mux, out_write, out_wr_addr}, 32'h18);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b01, 6'd0, 1'b0);

    // RAW on r3: stall until writeback, accept on the clearing cycle
    step(1'b1, 16'hC300, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    repeat (3) begin
      step(1'b1, 16'hD900, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
      check_eq("raw_stall", {31'd0, out_valid}, 32'd0);
    end
    step(1'b1, 16'hD900, 1'b1, 1'b0, 2'b10, {3'd3, 3'd0}, 1'b0);
    check_eq("raw_accept", {15'd0, out_valid, out_cmd}, {15'd0, 1'b1, 16'hD900});
    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, {3'd1, 3'd1}, 1'b0);

    // Backpressure for 5 cycles, then release
    step(1'b1, 16'h8200, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    repeat (5) begin
      step(1'b1, 16'h8400, 1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
      check_eq("bp_hold", {15'd0, out_valid, out_cmd}, {15'd0, 1'b1, 16'h8200});
    end
    step(1'b1, 16'h8400, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    check_eq("bp_release", {16'd0, out_cmd}, 32'h8400);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, {3'd4, 3'd2}, 1'b0);

    // Flush a held LI r5
    step(1'b1, 16'h8500, 1'b0, 1'b0, 2'b00, 6'd0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 2'b00, 6'd0, 1'b0);
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_sb", {31'd0, busy}, 32'd0);

    // Fill the scoreboard, then reset with a held bundle
    for (int r = 0; r < 8; r++) begin
      c = 16'h8000 | 16'(r << 8);
      step(1'b1, c, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 6'd0, 1'b1);
    check_eq("rst_state", {27'd0, out_valid, busy, out_alu_sel}, 32'h0F);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 2'b00, 6'd0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic [1:0] wv;
      wv[0] = ($urandom_range(0, 2) == 0);
      wv[1] = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), wv, 6'($urandom), ($urandom_range(0, 299) == 0));
    end
    in_valid = 1'b0;

    // Every encoding through the scoreboard-less build, one per cycle
    @(negedge clk);
    s_rst = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      s_cmd = 16'(i);
      #1;
      check_eq("nosb_ready", {31'd0, s_in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_eq("sweep", {s_bund, s_out_cmd, s_out_valid}, {ref_dec(16'(i)), 16'(i), 1'b1});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
